// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mem_access_ctrl                                              |
// | Purpose : MEM-stage data-memory sequencer: aligned 64-bit beats with   |
// |           valid/ready handshake, store lane shifting, load extension.  |
// |           Optional macro MISALIGN_SPLIT_EN enables two-beat crossings. |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module mem_access_ctrl #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [2:0]        memdata_width,
    output logic              stall,
    output logic              done,
    output logic [63:0]       load_data,
    output logic              misalign_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_rdata
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_REQ0  = 3'd1;
    localparam logic [2:0] c_WAIT0 = 3'd2;
`ifdef MISALIGN_SPLIT_EN
    localparam logic [2:0] c_REQ1  = 3'd3;
    localparam logic [2:0] c_WAIT1 = 3'd4;
`endif
    localparam logic [2:0] c_DONE  = 3'd5;

    function automatic logic [3:0] f_size(input logic [2:0] width);
        case (width)
            3'b001:        f_size = 4'd8;
            3'b010, 3'b101: f_size = 4'd4;
            3'b011, 3'b110: f_size = 4'd2;
            default:       f_size = 4'd1;
        endcase
    endfunction

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [63:0]       r_wdata;
    logic [2:0]        r_width;
    logic [63:0]       r_load_data;

    logic [2:0]        w_off;
    logic [3:0]        w_size;
    logic              w_cross;
    logic              w_in_cross;
    logic              w_accept;
    logic              w_load_en;
    logic [ADDR_W-1:0] w_base;
    logic [7:0]        w_mask0;
    logic [63:0]       w_wdata0;
    logic [63:0]       w_beat0;
    logic [63:0]       w_beat1;
    logic [63:0]       w_low;
    logic [63:0]       w_ext;

    assign w_off      = r_addr[2:0];
    assign w_size     = f_size(r_width);
    assign w_cross    = ({1'b0, w_off} + w_size) > 4'd8;
    assign w_in_cross = ({1'b0, req_addr[2:0]} + f_size(memdata_width)) > 4'd8;
    assign w_accept   = (r_state == c_IDLE) && req_valid && (memdata_width != 3'b000);
    assign w_base     = {r_addr[ADDR_W-1:3], 3'b000};
    assign w_mask0    = 8'(((16'd1 << w_size) - 16'd1) << w_off);
    assign w_wdata0   = r_wdata << {w_off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
    logic [63:0] r_beat0;
    logic [7:0]  w_mask1;
    logic [63:0] w_wdata1;

    // Second beat carries whatever spilled above byte lane 7.
    assign w_mask1  = 8'((((16'd1 << w_size) - 16'd1) << w_off) >> 8);
    assign w_wdata1 = r_wdata >> (7'd64 - {1'b0, w_off, 3'b000});
    assign w_beat0  = (r_state == c_WAIT1) ? r_beat0 : mem_rdata;
    assign w_beat1  = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat0 <= 64'd0;
        end else if (r_state == c_WAIT0 && mem_resp_valid) begin
            r_beat0 <= mem_rdata;
        end
    end
`else
    assign w_beat0 = mem_rdata;
    assign w_beat1 = 64'd0;
`endif

    assign w_low = 64'({w_beat1, w_beat0} >> {w_off, 3'b000});

    always_comb begin
        case (r_width)
            3'b010:  w_ext = {{32{w_low[31]}}, w_low[31:0]};
            3'b011:  w_ext = {{48{w_low[15]}}, w_low[15:0]};
            3'b100:  w_ext = {{56{w_low[7]}},  w_low[7:0]};
            3'b101:  w_ext = {32'd0, w_low[31:0]};
            3'b110:  w_ext = {48'd0, w_low[15:0]};
            3'b111:  w_ext = {56'd0, w_low[7:0]};
            default: w_ext = w_low;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
`ifdef MISALIGN_SPLIT_EN
                    w_next_state = c_REQ0;
`else
                    w_next_state = w_in_cross ? c_DONE : c_REQ0;
`endif
                end
            end
            c_REQ0:  if (mem_req_ready) w_next_state = c_WAIT0;
            c_WAIT0: begin
                if (mem_resp_valid) begin
`ifdef MISALIGN_SPLIT_EN
                    w_next_state = w_cross ? c_REQ1 : c_DONE;
`else
                    w_next_state = c_DONE;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            c_REQ1:  if (mem_req_ready)  w_next_state = c_WAIT1;
            c_WAIT1: if (mem_resp_valid) w_next_state = c_DONE;
`endif
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Only a completed memory read may update the result; the unsplit
    // crossing path reaches DONE straight from IDLE and never qualifies.
    assign w_load_en = ((r_state == c_WAIT0)
`ifdef MISALIGN_SPLIT_EN
                        || (r_state == c_WAIT1)
`endif
                       ) && (w_next_state == c_DONE) && !r_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= 64'd0;
            r_width     <= 3'd0;
            r_load_data <= 64'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_width <= memdata_width;
            end
            if (w_load_en) r_load_data <= w_ext;
        end
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wdata     = 64'd0;
        mem_wmask     = 8'd0;
        case (r_state)
            c_REQ0: begin
                mem_req_valid = 1'b1;
                mem_addr      = w_base;
                mem_wdata     = w_wdata0;
                mem_wmask     = w_mask0;
            end
`ifdef MISALIGN_SPLIT_EN
            c_REQ1: begin
                mem_req_valid = 1'b1;
                mem_addr      = w_base + ADDR_W'(8);
                mem_wdata     = w_wdata1;
                mem_wmask     = w_mask1;
            end
`endif
            default: ;
        endcase
    end

    assign mem_wen   = mem_req_valid && r_we;
    assign stall     = req_valid && (memdata_width != 3'b000) && (r_state != c_DONE);
    assign done      = (r_state == c_DONE);
    assign load_data = r_load_data;
`ifdef MISALIGN_SPLIT_EN
    assign misalign_err = 1'b0;
`else
    assign misalign_err = (r_state == c_DONE) && w_cross;
`endif

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM-stage data-memory port. It accepts one load/store per instruction from the pipeline and issues the aligned 64-bit access to data memory with a valid/ready handshake. It waits for the response, then aligns and sign- or zero-extends load data per the `memdata_width` encoding. The pipeline is held through `stall` until the access completes.

## Interface
- `ADDR_W`, default 64: address width.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: MEM stage holds a memory instruction; held stable while `stall`=1.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_addr  in  ADDR_W`: byte address.
- `req_wdata  in  64`: store data, right-justified.
- `memdata_width  in  3`: access width code.
  - 001 DW, 010 W, 011 HW, 100 B, 101 UW, 110 UHW, 111 UB.
  - 000 means no access.
- `stall  out  1`: pipeline hold.
- `done  out  1`: one-cycle completion pulse.
- `load_data  out  64`: extended load result, registered.
- `misalign_err  out  1`: one-cycle pulse on an unsupported misaligned access.
- `mem_req_valid  out  1`, `mem_req_ready  in  1`: request handshake.
- `mem_addr  out  ADDR_W`: 8-byte-aligned address; bits [2:0] are always 0.
- `mem_wen  out  1`: write enable.
- `mem_wdata  out  64`: lane-shifted write data.
- `mem_wmask  out  8`: byte-lane mask.
- `mem_resp_valid  in  1`, `mem_rdata  in  64`: response; one response per accepted request, for both reads and write acks.

## Operation
- Access size is 8/4/2/1 bytes; each unsigned code has the same size as its signed counterpart.
- Offset: `off = req_addr[2:0]`.
- Crossing: an access crosses when `off + size > 8`.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE:
  - `req_valid` with width ≠ 000 captures addr/we/wdata/width and goes to REQ0.
  - Width 000 is ignored and `stall` stays 0.
- REQ0 (first beat):
  - Drive `mem_addr = {addr[ADDR_W-1:3],3'b0}`.
  - Drive `mem_wmask = ((1<<size)-1) << off`, truncated to 8 bits.
  - Drive `mem_wdata = wdata << (off*8)`.
  - Go to WAIT0 on `mem_req_ready`.
- WAIT0:
  - On `mem_resp_valid`, latch `mem_rdata` as beat0.
  - Go to REQ1 if crossing, else DONE.
- REQ1/WAIT1 (second beat):
  - Address is the aligned address + 8.
  - Mask = the bits of `((1<<size)-1)<<off` above bit 7, shifted down 8.
  - Data = `wdata >> ((8-off)*8)`.
- Load assembly:
  - Combine as `{beat1,beat0} >> (off*8)` and take the low `size` bytes.
  - Sign-extend for DW/W/HW/B; zero-extend for UW/UHW/UB.
  - Write `load_data` on entry to DONE.
  - Stores leave `load_data` unchanged.
- DONE: `done`=1 for one cycle, then IDLE.
- `stall = req_valid && width≠000 && state≠DONE`.
  - The MEM stage advances at the end of the DONE cycle.
  - A new request is accepted in the following IDLE cycle.
- `mem_req_valid` is 1 only in REQ0/REQ1.
  - Address, mask and data stay stable until the handshake.
- `mem_resp_valid` is ignored outside WAIT0/WAIT1.

## Timing
- Reset: state IDLE, `stall`/`done`/`misalign_err`/`mem_req_valid`/`mem_wen` = 0, `mem_addr`/`mem_wdata`/`mem_wmask` = 0, `load_data` = 0.
- Minimum aligned latency with ready=1 and a 1-cycle response:
  - IDLE accept, REQ0, WAIT0, DONE.
  - `done` comes 3 cycles after `req_valid` is first sampled.
- A crossing access adds 2 cycles minimum (REQ1, WAIT1).
- `mem_req_ready` low holds the REQx state indefinitely, with outputs stable.
- `rst` mid-access: return to IDLE next edge with all outputs at reset values; any later stale response is ignored.
- `req_valid` dropping mid-access is illegal; behaviour is unspecified.

## Configuration
- `MISALIGN_SPLIT_EN` defined:
  - Crossing accesses run the two-beat sequence above.
  - `misalign_err` is tied 0.
- Not defined:
  - REQ1/WAIT1 are not built.
  - A crossing access goes IDLE→DONE with no memory request.
  - DONE asserts `misalign_err`=1 together with `done`; `load_data` is unchanged.
  - Non-crossing misaligned accesses (e.g. HW at off=2) are still supported.

## Test plan
- Aligned LB:
  - Setup: addr 0x1003, memory word 0x0123_4567_89AB_CDEF.
  - Expect `load_data`=0xFFFF_FFFF_FFFF_FF89 and `mem_addr`=0x1000.
  - Same access as LBU: expect `load_data`=0x89.
- SW:
  - Setup: addr 0x2004, wdata 0xDEADBEEF.
  - Expect `mem_wmask`=0xF0, `mem_wdata`=0xDEADBEEF_0000_0000, `mem_wen`=1.
- Backpressure: `mem_req_ready` low 5 cycles then high.
  - Expect `mem_req_valid`/`mem_addr` stable throughout and `stall`=1 until the DONE cycle.
- Crossing LW at addr 0x0006, with split enabled:
  - Beat0 0xAABB_0000_0000_0000, beat1 0x0000_0000_0000_CCDD.
  - Expect two requests, at 0x0000 then 0x0008.
  - Expect `load_data`=0xFFFF_FFFF_CCDD_AABB.
  - Split disabled: expect no request and `misalign_err`=1 with `done`.
- Crossing SD at addr 0x0005, with split enabled:
  - Expect masks 0xE0 then 0x1F.
- Reset in WAIT0:
  - Expect all outputs at reset values next cycle.
  - A following `mem_resp_valid` must not produce `done`.
